// File: rtl/sbp_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : sbp_result_collector_if
// Description : Lookup-completion and result-drain signals of the collector.
// Revision    : 1.0
// ============================================================================
interface sbp_result_collector_if #(
  parameter int CNT_BITS = 4
);
  logic                issue_i;
  logic                valid_i;
  logic [31:0]         ip_addr_i;
  logic [31:0]         result_i;
  logic [5:0]          stage_id_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_ip_addr_o;
  logic [31:0]         out_result_o;
  logic [5:0]          out_stage_id_o;
  logic                out_hit_o;
  logic                can_issue_o;
  logic [CNT_BITS-1:0] credits_o;
  logic                overflow_o;
  logic                underflow_o;
  logic                issue_err_o;

  // Collector side
  modport slave (
    input  issue_i, valid_i, ip_addr_i, result_i, stage_id_i, out_ready_i,
    output out_valid_o, out_ip_addr_o, out_result_o, out_stage_id_o,
    output out_hit_o, can_issue_o, credits_o,
    output overflow_o, underflow_o, issue_err_o
  );

  // Pipeline / consumer side
  modport master (
    output issue_i, valid_i, ip_addr_i, result_i, stage_id_i, out_ready_i,
    input  out_valid_o, out_ip_addr_o, out_result_o, out_stage_id_o,
    input  out_hit_o, can_issue_o, credits_o,
    input  overflow_o, underflow_o, issue_err_o
  );
endinterface
`default_nettype wire

// File: rtl/sbp_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : sbp_result_collector
// Description : Credit-managed result FIFO at the tail of the lookup pipeline.
// Revision    : 1.0
// ============================================================================
module sbp_result_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BITS   = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  sbp_result_collector_if.slave bus
);
  localparam int                  c_ptr_bits   = $clog2(FIFO_DEPTH);
  localparam int                  c_entry_bits = 70;
  localparam logic [CNT_BITS-1:0] c_depth      = CNT_BITS'(FIFO_DEPTH);

  logic [c_entry_bits-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_bits-1:0]   r_wr_ptr;
  logic [c_ptr_bits-1:0]   r_rd_ptr;
  logic [CNT_BITS-1:0]     r_count;
  logic [CNT_BITS-1:0]     r_inflight;
  logic [CNT_BITS-1:0]     r_credits;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    r_issue_err;

  logic                    w_pop;
  logic                    w_push;
  logic                    w_can_issue;
  logic                    w_inc;
  logic                    w_dec;
  logic [CNT_BITS-1:0]     w_count_nxt;
  logic [CNT_BITS-1:0]     w_inflight_nxt;
  logic [CNT_BITS:0]       w_used;
  logic [CNT_BITS-1:0]     w_credits_nxt;
  logic [c_entry_bits-1:0] w_head;

  always_comb begin
    w_pop          = (r_count != '0) && bus.out_ready_i;
    w_push         = bus.valid_i && ((r_count < c_depth) || w_pop);
    w_can_issue    = (r_credits != '0);
    w_inc          = bus.issue_i && w_can_issue;
    // A finished lookup only retires accounting that actually exists.
    w_dec          = bus.valid_i && ((r_inflight != '0) || w_inc);
    w_count_nxt    = r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
    w_inflight_nxt = r_inflight + CNT_BITS'(w_inc) - CNT_BITS'(w_dec);
    w_used         = {1'b0, w_count_nxt} + {1'b0, w_inflight_nxt};
    // Unaccounted (underflow) pushes can overcommit; clamp credits at zero.
    w_credits_nxt  = (w_used >= {1'b0, c_depth}) ? '0 : (c_depth - w_used[CNT_BITS-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_credits   <= c_depth;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_issue_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_bits'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_bits'(1);
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      r_credits  <= w_credits_nxt;
      if (bus.issue_i && !w_can_issue)                  r_issue_err <= 1'b1;
      if (bus.valid_i && !w_push)                       r_overflow  <= 1'b1;
      if (bus.valid_i && (r_inflight == '0) && !w_inc)  r_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr] <= {bus.ip_addr_i, bus.result_i, bus.stage_id_i};
  end

  assign w_head             = r_mem[r_rd_ptr];
  assign bus.out_valid_o    = (r_count != '0);
  assign bus.out_ip_addr_o  = w_head[69:38];
  assign bus.out_result_o   = w_head[37:6];
  assign bus.out_stage_id_o = w_head[5:0];
  assign bus.out_hit_o      = (w_head[37:6] != 32'd0);
  assign bus.can_issue_o    = w_can_issue;
  assign bus.credits_o      = r_credits;
  assign bus.overflow_o     = r_overflow;
  assign bus.underflow_o    = r_underflow;
  assign bus.issue_err_o    = r_issue_err;
endmodule
`default_nettype wire

// File: tb/tb_sbp_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbp_result_collector
// Description : Directed self-checking bench for sbp_result_collector.
// Revision    : 1.0
// ============================================================================
module tb_sbp_result_collector;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] exp_ip  [9];
  logic [31:0] exp_res [9];
  logic [5:0]  exp_st  [9];

  sbp_result_collector_if #(.CNT_BITS(4)) bus ();

  sbp_result_collector #(.FIFO_DEPTH(8), .CNT_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.ip_addr_i   = '0;
    bus.result_i    = '0;
    bus.stage_id_i  = '0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue_i = 1'b1;
      step();
    end
    bus.issue_i = 1'b0;
  endtask

  task automatic deliver(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.valid_i    = 1'b1;
      bus.ip_addr_i  = exp_ip[i];
      bus.result_i   = exp_res[i];
      bus.stage_id_i = exp_st[i];
      step();
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid_o); end
    checks++; if (bus.can_issue_o !== 1'b1) begin errors++; $display("FAIL rst_can_issue got %b exp 1", bus.can_issue_o); end
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL rst_credits got %0d exp 8", bus.credits_o); end
    checks++; if ({bus.overflow_o, bus.underflow_o, bus.issue_err_o} !== 3'b000)
      begin errors++; $display("FAIL rst_flags got %b exp 000", {bus.overflow_o, bus.underflow_o, bus.issue_err_o}); end
  endtask

  task automatic test_single_lookup();
    bus.issue_i = 1'b1;
    step();
    bus.issue_i = 1'b0;
    checks++; if (bus.credits_o !== 4'd7) begin errors++; $display("FAIL single_credits_issue got %0d exp 7", bus.credits_o); end
    repeat (9) step();
    checks++; if (bus.credits_o !== 4'd7) begin errors++; $display("FAIL single_credits_wait got %0d exp 7", bus.credits_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.out_valid_o); end
    bus.valid_i    = 1'b1;
    bus.ip_addr_i  = 32'h0A00_0001;
    bus.result_i   = 32'h0000_0005;
    bus.stage_id_i = 6'd17;
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", bus.out_valid_o); end
    checks++; if (bus.out_ip_addr_o !== 32'h0A00_0001) begin errors++; $display("FAIL single_ip got %h exp 0a000001", bus.out_ip_addr_o); end
    checks++; if (bus.out_result_o !== 32'h0000_0005) begin errors++; $display("FAIL single_result got %h exp 00000005", bus.out_result_o); end
    checks++; if (bus.out_stage_id_o !== 6'd17) begin errors++; $display("FAIL single_stage got %0d exp 17", bus.out_stage_id_o); end
    checks++; if (bus.out_hit_o !== 1'b1) begin errors++; $display("FAIL single_hit got %b exp 1", bus.out_hit_o); end
    checks++; if (bus.credits_o !== 4'd7) begin errors++; $display("FAIL single_credits_stored got %0d exp 7", bus.credits_o); end
    step();
    checks++; if (bus.out_ip_addr_o !== 32'h0A00_0001) begin errors++; $display("FAIL single_hold_ip got %h exp 0a000001", bus.out_ip_addr_o); end
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL single_popped_valid got %b exp 0", bus.out_valid_o); end
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL single_credits_pop got %0d exp 8", bus.credits_o); end
  endtask

  task automatic test_fill_credits();
    for (int i = 0; i < 8; i++) begin
      bus.issue_i = 1'b1;
      step();
      checks++; if (bus.credits_o !== 4'(7 - i)) begin errors++; $display("FAIL fill_credits[%0d] got %0d exp %0d", i, bus.credits_o, 7 - i); end
    end
    checks++; if (bus.can_issue_o !== 1'b0) begin errors++; $display("FAIL fill_can_issue got %b exp 0", bus.can_issue_o); end
    checks++; if (bus.issue_err_o !== 1'b0) begin errors++; $display("FAIL fill_err_early got %b exp 0", bus.issue_err_o); end
    step();
    bus.issue_i = 1'b0;
    checks++; if (bus.issue_err_o !== 1'b1) begin errors++; $display("FAIL fill_issue_err got %b exp 1", bus.issue_err_o); end
    checks++; if (bus.credits_o !== 4'd0) begin errors++; $display("FAIL fill_credits_9th got %0d exp 0", bus.credits_o); end
    deliver(0, 8);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b exp 0", bus.overflow_o); end
    checks++; if (bus.underflow_o !== 1'b0) begin errors++; $display("FAIL fill_underflow got %b exp 0", bus.underflow_o); end
    checks++; if (bus.out_ip_addr_o !== exp_ip[0]) begin errors++; $display("FAIL fill_head got %h exp %h", bus.out_ip_addr_o, exp_ip[0]); end
    checks++; if (bus.credits_o !== 4'd0) begin errors++; $display("FAIL fill_credits_full got %0d exp 0", bus.credits_o); end
  endtask

  task automatic test_full_push_pop();
    bus.valid_i     = 1'b1;
    bus.ip_addr_i   = exp_ip[8];
    bus.result_i    = exp_res[8];
    bus.stage_id_i  = exp_st[8];
    bus.out_ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b exp 0", bus.overflow_o); end
    checks++; if (bus.credits_o !== 4'd0) begin errors++; $display("FAIL pp_credits got %0d exp 0", bus.credits_o); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_ip_addr_o !== exp_ip[i] ||
          bus.out_result_o !== exp_res[i] || bus.out_stage_id_o !== exp_st[i]) begin
        errors++;
        $display("FAIL pp_order[%0d] got v=%b %h %h %0d exp v=1 %h %h %0d", i, bus.out_valid_o,
                 bus.out_ip_addr_o, bus.out_result_o, bus.out_stage_id_o, exp_ip[i], exp_res[i], exp_st[i]);
      end
      step();
    end
    bus.out_ready_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL pp_drained got %b exp 0", bus.out_valid_o); end
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL pp_credits_drained got %0d exp 8", bus.credits_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    issue_n(8);
    deliver(0, 8);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", bus.overflow_o); end
    bus.valid_i    = 1'b1;
    bus.ip_addr_i  = 32'hBAD0_0BAD;
    bus.result_i   = 32'h0000_0077;
    bus.stage_id_i = 6'd63;
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow_o); end
    repeat (3) step();
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow_o); end
    // Drain: the dropped entry must not appear behind the eight stored ones.
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_ip_addr_o !== exp_ip[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, bus.out_ip_addr_o, exp_ip[i]); end
      step();
    end
    bus.out_ready_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_dropped got %b exp 0", bus.out_valid_o); end
    do_reset();
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", bus.overflow_o); end
  endtask

  task automatic test_miss_underflow();
    bus.valid_i    = 1'b1;
    bus.ip_addr_i  = 32'h0B00_0002;
    bus.result_i   = 32'h0000_0000;
    bus.stage_id_i = 6'd5;
    step();
    bus.valid_i = 1'b0;
    checks++; if (bus.underflow_o !== 1'b1) begin errors++; $display("FAIL miss_underflow got %b exp 1", bus.underflow_o); end
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL miss_valid got %b exp 1", bus.out_valid_o); end
    checks++; if (bus.out_hit_o !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", bus.out_hit_o); end
    checks++; if (bus.out_ip_addr_o !== 32'h0B00_0002) begin errors++; $display("FAIL miss_ip got %h exp 0b000002", bus.out_ip_addr_o); end
    checks++; if (bus.credits_o !== 4'd7) begin errors++; $display("FAIL miss_credits got %0d exp 7", bus.credits_o); end
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL miss_credits_pop got %0d exp 8", bus.credits_o); end
  endtask

  task automatic test_mid_reset();
    issue_n(5);
    deliver(0, 3);
    checks++; if (bus.credits_o !== 4'd3) begin errors++; $display("FAIL mrst_credits_pre got %0d exp 3", bus.credits_o); end
    checks++; if (bus.underflow_o !== 1'b1) begin errors++; $display("FAIL mrst_flag_pre got %b exp 1", bus.underflow_o); end
    rst         = 1'b1;
    bus.issue_i = 1'b1;
    bus.valid_i = 1'b1;
    step();
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", bus.out_valid_o); end
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL mrst_credits got %0d exp 8", bus.credits_o); end
    checks++; if (bus.can_issue_o !== 1'b1) begin errors++; $display("FAIL mrst_can_issue got %b exp 1", bus.can_issue_o); end
    checks++; if ({bus.overflow_o, bus.underflow_o, bus.issue_err_o} !== 3'b000)
      begin errors++; $display("FAIL mrst_flags got %b exp 000", {bus.overflow_o, bus.underflow_o, bus.issue_err_o}); end
    rst = 1'b0;
    idle_inputs();
    step();
    checks++; if (bus.credits_o !== 4'd8) begin errors++; $display("FAIL mrst_credits_after got %0d exp 8", bus.credits_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_valid_after got %b exp 0", bus.out_valid_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      exp_ip[i]  = 32'hC0A8_0000 + 32'(i);
      exp_res[i] = 32'h0000_0100 + 32'(i);
      exp_st[i]  = 6'(i + 1);
    end
    test_reset();
    test_single_lookup();
    test_fill_credits();
    test_full_push_pop();
    test_overflow();
    test_miss_underflow();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
